// File: rtl/ctr_eng_arb.sv
// Per-engine config/busy/drain FSMs, shared GLB coordinate address arbiter and in-order
// read-data return through an outstanding-tag FIFO. Build macro: CTR_CONCURRENT_EN.
module ctr_eng_arb #(
  parameter int NUM_ENG     = 2,
  parameter int ENG_W       = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1,
  parameter int IDX_WIDTH   = 10,
  parameter int SRAM_WIDTH  = 256,
  parameter int OUTST_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           CCUCTR_CfgVld,
  output logic                           CTRCCU_CfgRdy,
  input  logic [ENG_W-1:0]               CCUCTR_CfgMod,
  output logic [NUM_ENG-1:0]             CTRCCU_Busy,
  output logic                           CTRCCU_Err,
  output logic [NUM_ENG-1:0]             CTRENG_CfgVld,
  input  logic [NUM_ENG-1:0]             ENGCTR_CfgRdy,
  input  logic [NUM_ENG-1:0]             ENGCTR_Done,
  input  logic [NUM_ENG*IDX_WIDTH-1:0]   ENGCTR_CrdAddr,
  input  logic [NUM_ENG-1:0]             ENGCTR_CrdAddrVld,
  output logic [NUM_ENG-1:0]             CTRENG_CrdAddrRdy,
  output logic [IDX_WIDTH-1:0]           CTRGLB_CrdAddr,
  output logic                           CTRGLB_CrdAddrVld,
  input  logic                           GLBCTR_CrdAddrRdy,
  input  logic [SRAM_WIDTH-1:0]          GLBCTR_Crd,
  input  logic                           GLBCTR_CrdVld,
  output logic                           CTRGLB_CrdRdy,
  output logic [SRAM_WIDTH-1:0]          CTRENG_Crd,
  output logic [NUM_ENG-1:0]             CTRENG_CrdVld,
  input  logic [NUM_ENG-1:0]             ENGCTR_CrdRdy
);
  localparam int PTR_W = $clog2(OUTST_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Handshakes: a transfer happens on a cycle where valid and ready are both high at
  // the clk edge; valid never depends on ready, ready may depend on valid.
  typedef enum logic [1:0] {ST_IDLE, ST_CFG, ST_BUSY, ST_DRAIN} eng_state_e;

  eng_state_e       state_q [NUM_ENG];
  eng_state_e       state_d [NUM_ENG];
  logic [CNT_W-1:0] outst_q [NUM_ENG];
  logic [CNT_W-1:0] outst_d [NUM_ENG];
  logic [ENG_W-1:0] tag_q   [OUTST_DEPTH];
  logic [ENG_W-1:0] cand    [NUM_ENG];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  logic [NUM_ENG-1:0] idle, elig;
  logic               mod_ok, tgt_idle, admit, cfg_hs;
  logic               fifo_empty, fifo_full, push, pop, can_push, found;
  logic [ENG_W-1:0]   gnt_idx, head, rr_start;

  always_comb begin
    idle     = '0;
    elig     = '0;
    mod_ok   = 1'b0;
    tgt_idle = 1'b0;
    for (int i = 0; i < NUM_ENG; i++) begin
      idle[i] = (state_q[i] == ST_IDLE);
      elig[i] = (state_q[i] == ST_BUSY) && ENGCTR_CrdAddrVld[i];
      if (CCUCTR_CfgMod == ENG_W'(i)) begin
        mod_ok   = 1'b1;
        tgt_idle = idle[i];
      end
    end
  end

`ifdef CTR_CONCURRENT_EN
  logic [ENG_W-1:0] rr_q;
  assign admit    = tgt_idle;
  assign rr_start = rr_q;
  always_ff @(posedge clk) begin
    if (rst) rr_q <= '0;
    else if (push) rr_q <= (gnt_idx == ENG_W'(NUM_ENG - 1)) ? '0 : gnt_idx + 1'b1;
  end
`else
  // Single active engine: all idle implies the target is idle too.
  assign admit    = tgt_idle && (&idle);
  assign rr_start = '0;
`endif

  assign CTRCCU_CfgRdy = mod_ok && admit;
  assign cfg_hs        = CCUCTR_CfgVld && CTRCCU_CfgRdy;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CNT_W'(OUTST_DEPTH));
  assign head       = tag_q[rd_ptr_q];
  assign pop        = GLBCTR_CrdVld && !fifo_empty && ENGCTR_CrdRdy[head];
  assign can_push   = !fifo_full || pop;

  // Highest offset first so the last hit is the one closest to the pointer.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_ENG; k++) cand[k] = ENG_W'((int'(rr_start) + k) % NUM_ENG);
    for (int k = NUM_ENG - 1; k >= 0; k--) begin
      if (elig[cand[k]]) begin
        found   = 1'b1;
        gnt_idx = cand[k];
      end
    end
  end

  assign CTRGLB_CrdAddrVld = found && can_push;
  assign push              = CTRGLB_CrdAddrVld && GLBCTR_CrdAddrRdy;
  assign CTRGLB_CrdRdy     = !fifo_empty && ENGCTR_CrdRdy[head];
  assign CTRENG_Crd        = fifo_empty ? '0 : GLBCTR_Crd;
  assign CTRCCU_Err        = err_q;

  always_comb begin
    CTRENG_CrdAddrRdy = '0;
    CTRGLB_CrdAddr    = '0;
    CTRENG_CrdVld     = '0;
    if (CTRGLB_CrdAddrVld) begin
      CTRENG_CrdAddrRdy[gnt_idx] = GLBCTR_CrdAddrRdy;
      CTRGLB_CrdAddr = ENGCTR_CrdAddr[int'(gnt_idx)*IDX_WIDTH +: IDX_WIDTH];
    end
    if (!fifo_empty) CTRENG_CrdVld[head] = GLBCTR_CrdVld;
  end

  always_comb begin
    CTRENG_CfgVld = '0;
    CTRCCU_Busy   = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      state_d[i]       = state_q[i];
      outst_d[i]       = outst_q[i];
      CTRENG_CfgVld[i] = (state_q[i] == ST_CFG);
      CTRCCU_Busy[i]   = !idle[i];
      case (state_q[i])
        ST_IDLE:  if (cfg_hs && CCUCTR_CfgMod == ENG_W'(i)) state_d[i] = ST_CFG;
        ST_CFG:   if (ENGCTR_CfgRdy[i]) state_d[i] = ST_BUSY;
        ST_BUSY:  if (ENGCTR_Done[i]) state_d[i] = ST_DRAIN;
        ST_DRAIN: if (outst_q[i] == '0) state_d[i] = ST_IDLE;
        default:  state_d[i] = ST_IDLE;
      endcase
      if (push && gnt_idx == ENG_W'(i)) outst_d[i] = outst_d[i] + 1'b1;
      if (pop && head == ENG_W'(i))     outst_d[i] = outst_d[i] - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENG; i++) begin
        state_q[i] <= ST_IDLE;
        outst_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ENG; i++) begin
        state_q[i] <= state_d[i];
        outst_q[i] <= outst_d[i];
      end
      if (push) begin
        tag_q[wr_ptr_q] <= gnt_idx;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
      if (GLBCTR_CrdVld && fifo_empty) err_q <= 1'b1;
    end
  end
endmodule
